// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: instruction decode levels plus per-state strobes.
// Define MULDIV_EN to add the MD wait state and its cycle counter for mult/div.
module multicycle_control #(
  parameter int ADDR_HI_W     = 22,
  parameter int MULDIV_CYCLES = 32
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic [5:0]           Opcode,
  input  logic [5:0]           Function_opcode,
  input  logic [ADDR_HI_W-1:0] ALUResultHigh,
  input  logic                 io_ready,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IORead,
  output logic                 IOWrite,
  output logic                 write_HI_LO,
  output logic                 RegDST,
  output logic                 ALUSrc,
  output logic                 MemOrIOtoReg,
  output logic                 Branch,
  output logic                 nBranch,
  output logic                 Jmp,
  output logic                 Jal,
  output logic                 Jr,
  output logic                 I_format,
  output logic                 Sftmd,
  output logic [1:0]           ALUOp,
  output logic [1:0]           move_HI_LO,
  output logic [2:0]           state,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_MD  = 3'd5,
    S_IOW = 3'd6
  } state_t;

  state_t state_q;

`ifdef MULDIV_EN
  localparam logic [5:0] MD_LOAD = 6'(MULDIV_CYCLES - 1);
  logic [5:0] md_count;
`else
  localparam int unused_muldiv_cycles = MULDIV_CYCLES;
`endif

  logic r_format, lw, sw, mem_op, jump_any, io_sel;
  logic mfhi, mflo, mthilo, muldiv, hilo_class;

  assign r_format   = (Opcode == 6'b000000);
  assign lw         = (Opcode == 6'b100011);
  assign sw         = (Opcode == 6'b101011);
  assign mem_op     = lw | sw;
  assign mfhi       = r_format && (Function_opcode == 6'b010000);
  assign mflo       = r_format && (Function_opcode == 6'b010010);
  assign mthilo     = r_format && ((Function_opcode == 6'b010001) || (Function_opcode == 6'b010011));
  assign muldiv     = r_format && (Function_opcode[5:2] == 4'b0110);
  assign hilo_class = r_format && ((Function_opcode[5:2] == 4'b0100) || (Function_opcode[5:2] == 4'b0110));
  assign io_sel     = &ALUResultHigh;

  assign RegDST       = r_format;
  assign I_format     = (Opcode[5:3] == 3'b001);
  assign ALUSrc       = I_format | mem_op;
  assign MemOrIOtoReg = lw;
  assign Branch       = (Opcode == 6'b000100);
  assign nBranch      = (Opcode == 6'b000101);
  assign Jmp          = (Opcode == 6'b000010);
  assign Jal          = (Opcode == 6'b000011);
  assign Jr           = r_format && (Function_opcode == 6'b001000);
  assign Sftmd        = r_format && (Function_opcode[5:3] == 3'b000);
  assign ALUOp        = {r_format | I_format, Branch | nBranch};
  assign move_HI_LO   = {mfhi, mflo};
  assign jump_any     = Branch | nBranch | Jmp | Jr;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IF;
`ifdef MULDIV_EN
      md_count <= 6'd0;
`endif
    end else begin
      case (state_q)
        S_IF: state_q <= S_ID;
        S_ID: state_q <= S_EX;
        S_EX: begin
          if (jump_any)    state_q <= S_IF;
          else if (Jal)    state_q <= S_WB;
          else if (mem_op) state_q <= S_MEM;
          else if (muldiv) begin
`ifdef MULDIV_EN
            state_q  <= S_MD;
            md_count <= MD_LOAD;
`else
            state_q  <= S_IF;
`endif
          end
          else if (mthilo) state_q <= S_IF;
          else             state_q <= S_WB;
        end
        S_MEM: begin
          if (io_sel && !io_ready) state_q <= S_IOW;
          else if (lw)             state_q <= S_WB;
          else                     state_q <= S_IF;
        end
        S_IOW: begin
          if (io_ready) state_q <= lw ? S_WB : S_IF;
        end
        S_WB: state_q <= S_IF;
`ifdef MULDIV_EN
        S_MD: begin
          if (md_count == 6'd0) state_q  <= S_IF;
          else                  md_count <= md_count - 6'd1;
        end
`endif
        default: state_q <= S_IF;
      endcase
    end
  end

  logic ir_w, pc_w, reg_w, mem_r, mem_w, io_r, io_w, hl_w, busy_c;

  always_comb begin
    ir_w   = 1'b0;
    pc_w   = 1'b0;
    reg_w  = 1'b0;
    mem_r  = 1'b0;
    mem_w  = 1'b0;
    io_r   = 1'b0;
    io_w   = 1'b0;
    hl_w   = 1'b0;
    busy_c = 1'b0;
    case (state_q)
      S_IF: ir_w = 1'b1;
      S_EX: begin
        if (jump_any) pc_w = 1'b1;
        else if (!Jal && !mem_op) begin
          if (muldiv) begin
`ifdef MULDIV_EN
            pc_w = 1'b0;
`else
            pc_w = 1'b1;
`endif
          end else if (mthilo) begin
            pc_w = 1'b1;
            hl_w = 1'b1;
          end
        end
      end
      S_MEM: begin
        if (io_sel) begin
          io_r = lw;
          io_w = !lw;
          pc_w = !lw && io_ready;
        end else begin
          mem_r = lw;
          mem_w = !lw;
          pc_w  = !lw;
        end
      end
      S_IOW: begin
        io_r   = lw;
        io_w   = !lw;
        pc_w   = !lw && io_ready;
        busy_c = 1'b1;
      end
      S_WB: begin
        pc_w  = 1'b1;
        reg_w = !(Jr || (hilo_class && !mfhi && !mflo));
      end
`ifdef MULDIV_EN
      S_MD: begin
        busy_c = 1'b1;
        if (md_count == 6'd0) begin
          hl_w = 1'b1;
          pc_w = 1'b1;
        end
      end
`endif
      default: begin
      end
    endcase
  end

  // Gating with rst_n makes reset silence every strobe without waiting for a clock edge
  assign IRWrite     = ir_w   & rst_n;
  assign PCWrite     = pc_w   & rst_n;
  assign RegWrite    = reg_w  & rst_n;
  assign MemRead     = mem_r  & rst_n;
  assign MemWrite    = mem_w  & rst_n;
  assign IORead      = io_r   & rst_n;
  assign IOWrite     = io_w   & rst_n;
  assign write_HI_LO = hl_w   & rst_n;
  assign busy        = busy_c & rst_n;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes per-cycle expectations, a negedge monitor compares.
module tb_multicycle_control;

  logic        clock, rst_n;
  logic [5:0]  Opcode, Function_opcode;
  logic [21:0] ALUResultHigh;
  logic        io_ready;
  logic        IRWrite, PCWrite, RegWrite, MemRead, MemWrite, IORead, IOWrite, write_HI_LO;
  logic        RegDST, ALUSrc, MemOrIOtoReg, Branch, nBranch, Jmp, Jal, Jr, I_format, Sftmd;
  logic [1:0]  ALUOp, move_HI_LO;
  logic [2:0]  state;
  logic        busy;

  multicycle_control #(.ADDR_HI_W(22), .MULDIV_CYCLES(32)) dut (
    .clock(clock), .rst_n(rst_n), .Opcode(Opcode), .Function_opcode(Function_opcode),
    .ALUResultHigh(ALUResultHigh), .io_ready(io_ready),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .IORead(IORead), .IOWrite(IOWrite), .write_HI_LO(write_HI_LO),
    .RegDST(RegDST), .ALUSrc(ALUSrc), .MemOrIOtoReg(MemOrIOtoReg), .Branch(Branch),
    .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal), .Jr(Jr), .I_format(I_format), .Sftmd(Sftmd),
    .ALUOp(ALUOp), .move_HI_LO(move_HI_LO), .state(state), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [2:0] IF = 3'd0, ID = 3'd1, EX = 3'd2, MEM = 3'd3, WB = 3'd4, MD = 3'd5, IOW = 3'd6;

  // strobe order: IRWrite PCWrite RegWrite MemRead MemWrite IORead IOWrite write_HI_LO
  localparam logic [7:0] P_NONE = 8'h00, P_IF = 8'h80, P_PC = 8'h40, P_WB = 8'h60, P_MRD = 8'h10;
  localparam logic [7:0] P_SWM = 8'h48, P_IORD = 8'h04, P_IOWR = 8'h02, P_IOWPC = 8'h42, P_HL = 8'h41;

  // decode order: RegDST ALUSrc MemOrIOtoReg Branch nBranch Jmp Jal Jr I_format Sftmd ALUOp move_HI_LO
  localparam logic [13:0] D_R    = 14'b1000000000_10_00;
  localparam logic [13:0] D_LW   = 14'b0110000000_00_00;
  localparam logic [13:0] D_SW   = 14'b0100000000_00_00;
  localparam logic [13:0] D_BEQ  = 14'b0001000000_01_00;
  localparam logic [13:0] D_ADDI = 14'b0100000010_10_00;
  localparam logic [13:0] D_JAL  = 14'b0000001000_00_00;
  localparam logic [13:0] D_JR   = 14'b1000000100_10_00;
  localparam logic [13:0] D_MFHI = 14'b1000000000_10_10;
  localparam logic [13:0] D_SLL  = 14'b1000000001_10_00;

  typedef struct {
    logic [2:0]  st;
    logic [7:0]  strb;
    logic        bsy;
    logic        chk_dec;
    logic [13:0] dec;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fails  = 0;
  logic [13:0] cur_dec;
  logic        cur_chk;
  string       cur_tag;

  task automatic checkOutput(input exp_t e);
    logic [7:0]  act_strb;
    logic [13:0] act_dec;
    act_strb = {IRWrite, PCWrite, RegWrite, MemRead, MemWrite, IORead, IOWrite, write_HI_LO};
    act_dec  = {RegDST, ALUSrc, MemOrIOtoReg, Branch, nBranch, Jmp, Jal, Jr, I_format, Sftmd, ALUOp, move_HI_LO};
    n_checks++;
    if (state !== e.st) begin
      n_fails++;
      $display("[TB] FAIL %s state: got %0d expected %0d at %0t", e.tag, state, e.st, $time);
    end
    n_checks++;
    if (act_strb !== e.strb) begin
      n_fails++;
      $display("[TB] FAIL %s strobes: got %b expected %b at %0t", e.tag, act_strb, e.strb, $time);
    end
    n_checks++;
    if (busy !== e.bsy) begin
      n_fails++;
      $display("[TB] FAIL %s busy: got %b expected %b at %0t", e.tag, busy, e.bsy, $time);
    end
    if (e.chk_dec) begin
      n_checks++;
      if (act_dec !== e.dec) begin
        n_fails++;
        $display("[TB] FAIL %s decode: got %b expected %b at %0t", e.tag, act_dec, e.dec, $time);
      end
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle on the falling edge
  initial begin
    forever begin
      @(negedge clock);
      if (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic [21:0] hi,
                               input logic rdy, input logic [13:0] dec, input string tag);
    Opcode          = op;
    Function_opcode = fn;
    ALUResultHigh   = hi;
    io_ready        = rdy;
    cur_dec         = dec;
    cur_chk         = 1'b1;
    cur_tag         = tag;
  endtask

  task automatic expectCycle(input logic [2:0] st, input logic [7:0] strb, input logic bsy);
    exp_t e;
    e.st = st; e.strb = strb; e.bsy = bsy; e.chk_dec = cur_chk; e.dec = cur_dec; e.tag = cur_tag;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  // Asserted between edges so the monitor sees the async effect before the next edge
  task automatic midReset(input string tag);
    #1 rst_n = 1'b0;
    cur_chk = 1'b0;
    cur_tag = tag;
    expectCycle(IF, P_NONE, 1'b0);
    expectCycle(IF, P_NONE, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    Opcode = 6'd0; Function_opcode = 6'd0; ALUResultHigh = 22'd0; io_ready = 1'b1;
    cur_dec = 14'd0; cur_chk = 1'b0; cur_tag = "reset";
    @(posedge clock);
    #1;
    expectCycle(IF, P_NONE, 1'b0);
    expectCycle(IF, P_NONE, 1'b0);
    rst_n = 1'b1;

    applyStimulus(6'b000000, 6'b100000, 22'h0, 1'b1, D_R, "add");
    expectCycle(IF, P_IF, 0); expectCycle(ID, P_NONE, 0); expectCycle(EX, P_NONE, 0); expectCycle(WB, P_WB, 0);

    applyStimulus(6'b000100, 6'b000000, 22'h0, 1'b1, D_BEQ, "beq");
    expectCycle(IF, P_IF, 0); expectCycle(ID, P_NONE, 0); expectCycle(EX, P_PC, 0);

    applyStimulus(6'b101011, 6'b000000, 22'h000001, 1'b1, D_SW, "sw_mem");
    expectCycle(IF, P_IF, 0); expectCycle(ID, P_NONE, 0); expectCycle(EX, P_NONE, 0); expectCycle(MEM, P_SWM, 0);

    applyStimulus(6'b100011, 6'b000000, 22'h3FFFFE, 1'b1, D_LW, "lw_mem");
    expectCycle(IF, P_IF, 0); expectCycle(ID, P_NONE, 0); expectCycle(EX, P_NONE, 0);
    expectCycle(MEM, P_MRD, 0); expectCycle(WB, P_WB, 0);

    applyStimulus(6'b100011, 6'b000000, 22'h3FFFFF, 1'b0, D_LW, "lw_io_wait");
    expectCycle(IF, P_IF, 0); expectCycle(ID, P_NONE, 0); expectCycle(EX, P_NONE, 0);
    expectCycle(MEM, P_IORD, 0); expectCycle(IOW, P_IORD, 1); expectCycle(IOW, P_IORD, 1);
    io_ready = 1'b1;
    expectCycle(IOW, P_IORD, 1); expectCycle(WB, P_WB, 0);

    applyStimulus(6'b101011, 6'b000000, 22'h3FFFFF, 1'b1, D_SW, "sw_io_fast");
    expectCycle(IF, P_IF, 0); expectCycle(ID, P_NONE, 0); expectCycle(EX, P_NONE, 0); expectCycle(MEM, P_IOWPC, 0);

    applyStimulus(6'b101011, 6'b000000, 22'h3FFFFF, 1'b0, D_SW, "sw_io_wait");
    expectCycle(IF, P_IF, 0); expectCycle(ID, P_NONE, 0); expectCycle(EX, P_NONE, 0); expectCycle(MEM, P_IOWR, 0);
    io_ready = 1'b1;
    expectCycle(IOW, P_IOWPC, 1);

    applyStimulus(6'b001000, 6'b000101, 22'h0, 1'b1, D_ADDI, "addi");
    expectCycle(IF, P_IF, 0); expectCycle(ID, P_NONE, 0); expectCycle(EX, P_NONE, 0); expectCycle(WB, P_WB, 0);

    applyStimulus(6'b000011, 6'b000000, 22'h0, 1'b1, D_JAL, "jal");
    expectCycle(IF, P_IF, 0); expectCycle(ID, P_NONE, 0); expectCycle(EX, P_NONE, 0); expectCycle(WB, P_WB, 0);

    applyStimulus(6'b000000, 6'b001000, 22'h0, 1'b1, D_JR, "jr");
    expectCycle(IF, P_IF, 0); expectCycle(ID, P_NONE, 0); expectCycle(EX, P_PC, 0);

    applyStimulus(6'b000000, 6'b010000, 22'h0, 1'b1, D_MFHI, "mfhi");
    expectCycle(IF, P_IF, 0); expectCycle(ID, P_NONE, 0); expectCycle(EX, P_NONE, 0); expectCycle(WB, P_WB, 0);

    applyStimulus(6'b000000, 6'b010001, 22'h0, 1'b1, D_R, "mthi");
    expectCycle(IF, P_IF, 0); expectCycle(ID, P_NONE, 0); expectCycle(EX, P_HL, 0);

    applyStimulus(6'b000000, 6'b000000, 22'h0, 1'b1, D_SLL, "sll");
    expectCycle(IF, P_IF, 0); expectCycle(ID, P_NONE, 0); expectCycle(EX, P_NONE, 0); expectCycle(WB, P_WB, 0);

    applyStimulus(6'b000000, 6'b011000, 22'h0, 1'b1, D_R, "mult");
    expectCycle(IF, P_IF, 0); expectCycle(ID, P_NONE, 0);
`ifdef MULDIV_EN
    expectCycle(EX, P_NONE, 0);
    for (int i = 0; i < 31; i++) expectCycle(MD, P_NONE, 1);
    expectCycle(MD, P_HL, 1);
`else
    expectCycle(EX, P_PC, 0);
`endif

    applyStimulus(6'b100011, 6'b000000, 22'h3FFFFF, 1'b0, D_LW, "lw_io_rst");
    expectCycle(IF, P_IF, 0); expectCycle(ID, P_NONE, 0); expectCycle(EX, P_NONE, 0);
    expectCycle(MEM, P_IORD, 0); expectCycle(IOW, P_IORD, 1);
    midReset("rst_in_iow");

`ifdef MULDIV_EN
    applyStimulus(6'b000000, 6'b011010, 22'h0, 1'b1, D_R, "div_rst");
    expectCycle(IF, P_IF, 0); expectCycle(ID, P_NONE, 0); expectCycle(EX, P_NONE, 0);
    for (int i = 0; i < 21; i++) expectCycle(MD, P_NONE, 1);
    midReset("rst_in_md");
`endif

    applyStimulus(6'b000000, 6'b100001, 22'h0, 1'b1, D_R, "addu_after_rst");
    expectCycle(IF, P_IF, 0); expectCycle(ID, P_NONE, 0); expectCycle(EX, P_NONE, 0); expectCycle(WB, P_WB, 0);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clock);
    if (sb.size() > 0) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
